// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: single-stage MIPS-subset instruction decoder feeding the
// 32-bit ALU top. One instruction is accepted per valid/ready handshake and the
// decoded control word is registered, giving one cycle of latency and full
// throughput when the downstream drains while a new beat is accepted.
//
// Optional build macro: ALU_DEC_PERF_CNT_EN adds saturating DEC_COUNT and
// ILL_COUNT outputs (accepted beats, and accepted beats that were illegal).
module alu_ctrl_decoder #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_WIDTH-1:0] INSTR,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [3:0]            ALUC,
   output logic                  SHIFT,
   output logic                  ALUIMM,
   output logic [DATA_WIDTH-1:0] IMM_EXT,
   output logic [4:0]            RS,
   output logic [4:0]            RT,
   output logic [4:0]            RD_ADDR,
   output logic [4:0]            SA,
   output logic                  WREG,
   output logic                  M2REG,
   output logic                  WMEM,
   output logic [1:0]            BRANCH,
   output logic [1:0]            JUMP_TYPE,
   output logic                  ILLEGAL
`ifdef ALU_DEC_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  DEC_COUNT,
   output logic [CNT_WIDTH-1:0]  ILL_COUNT
`endif
);

   // Field extraction assumes the MIPS layout in the low 32 bits.
   if (DATA_WIDTH < 32 || CNT_WIDTH < 1) begin : g_param_check
      $error("alu_ctrl_decoder: DATA_WIDTH must be >= 32 and CNT_WIDTH >= 1");
   end

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;

   localparam logic [1:0] BR_BEQ = 2'b01;
   localparam logic [1:0] BR_BNE = 2'b10;
   localparam logic [1:0] JT_J   = 2'b01;
   localparam logic [1:0] JT_JAL = 2'b10;
   localparam logic [1:0] JT_JR  = 2'b11;

   localparam logic [4:0] LINK_REG = 5'd31;

   typedef struct packed {
      logic [3:0]            aluc;
      logic                  shift;
      logic                  aluimm;
      logic [DATA_WIDTH-1:0] imm_ext;
      logic [4:0]            rs;
      logic [4:0]            rt;
      logic [4:0]            rd_addr;
      logic [4:0]            sa;
      logic                  wreg;
      logic                  m2reg;
      logic                  wmem;
      logic [1:0]            branch;
      logic [1:0]            jump_type;
      logic                  illegal;
   } dec_t;

   // Widen the 16-bit immediate either arithmetically or with zeros.
   function automatic logic [DATA_WIDTH-1:0] ext_imm(input logic signed [15:0] imm,
                                                     input logic              sign_ext);
      logic signed [DATA_WIDTH-1:0] imm_s;
      logic        [DATA_WIDTH-1:0] imm_z;
      imm_s = {{(DATA_WIDTH-16){imm[15]}}, imm};
      imm_z = {{(DATA_WIDTH-16){1'b0}}, imm};
      return sign_ext ? imm_s : imm_z;
   endfunction

   logic [5:0] opcode_p0;
   logic [5:0] funct_p0;
   logic       accept_p0;
   dec_t       dec_p0;
   dec_t       dec_p1;
   logic       vld_p1;

   assign opcode_p0 = INSTR[31:26];
   assign funct_p0  = INSTR[5:0];
   assign IN_READY  = ~vld_p1 | OUT_READY;
   assign accept_p0 = IN_VALID & IN_READY;

   // ---- stage p0: combinational decode of the incoming instruction ----
   // Decode opcode/funct into the ALU control word; unknown encodings flag ILLEGAL.
   always_comb begin
      dec_p0         = '0;
      dec_p0.rs      = INSTR[25:21];
      dec_p0.rt      = INSTR[20:16];
      dec_p0.sa      = INSTR[10:6];
      dec_p0.imm_ext = ext_imm(INSTR[15:0], 1'b1);
      case (opcode_p0)
         OP_RTYPE: begin
            case (funct_p0)
               FN_ADD, FN_ADDU: begin
                  dec_p0.aluc    = ALU_ADD;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_SUB, FN_SUBU: begin
                  dec_p0.aluc    = ALU_SUB;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_AND: begin
                  dec_p0.aluc    = ALU_AND;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_OR: begin
                  dec_p0.aluc    = ALU_OR;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_XOR: begin
                  dec_p0.aluc    = ALU_XOR;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_SLL: begin
                  dec_p0.aluc    = ALU_SLL;
                  dec_p0.shift   = 1'b1;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_SRL: begin
                  dec_p0.aluc    = ALU_SRL;
                  dec_p0.shift   = 1'b1;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_SRA: begin
                  dec_p0.aluc    = ALU_SRA;
                  dec_p0.shift   = 1'b1;
                  dec_p0.wreg    = 1'b1;
                  dec_p0.rd_addr = INSTR[15:11];
               end
               FN_JR: begin
                  dec_p0.jump_type = JT_JR;
               end
               default: begin
                  dec_p0.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec_p0.aluc    = ALU_ADD;
            dec_p0.aluimm  = 1'b1;
            dec_p0.wreg    = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_ANDI: begin
            dec_p0.aluc    = ALU_AND;
            dec_p0.aluimm  = 1'b1;
            dec_p0.imm_ext = ext_imm(INSTR[15:0], 1'b0);
            dec_p0.wreg    = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_ORI: begin
            dec_p0.aluc    = ALU_OR;
            dec_p0.aluimm  = 1'b1;
            dec_p0.imm_ext = ext_imm(INSTR[15:0], 1'b0);
            dec_p0.wreg    = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_XORI: begin
            dec_p0.aluc    = ALU_XOR;
            dec_p0.aluimm  = 1'b1;
            dec_p0.imm_ext = ext_imm(INSTR[15:0], 1'b0);
            dec_p0.wreg    = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_LUI: begin
            dec_p0.aluc    = ALU_LUI;
            dec_p0.aluimm  = 1'b1;
            dec_p0.imm_ext = ext_imm(INSTR[15:0], 1'b0);
            dec_p0.wreg    = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_LW: begin
            dec_p0.aluc    = ALU_ADD;
            dec_p0.aluimm  = 1'b1;
            dec_p0.wreg    = 1'b1;
            dec_p0.m2reg   = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_SW: begin
            dec_p0.aluc    = ALU_ADD;
            dec_p0.aluimm  = 1'b1;
            dec_p0.wmem    = 1'b1;
            dec_p0.rd_addr = INSTR[20:16];
         end
         OP_BEQ: begin
            dec_p0.aluc   = ALU_SUB;
            dec_p0.branch = BR_BEQ;
         end
         OP_BNE: begin
            dec_p0.aluc   = ALU_SUB;
            dec_p0.branch = BR_BNE;
         end
         OP_J: begin
            dec_p0.jump_type = JT_J;
         end
         OP_JAL: begin
            dec_p0.jump_type = JT_JAL;
            dec_p0.wreg      = 1'b1;
            dec_p0.rd_addr   = LINK_REG;
         end
         default: begin
            dec_p0.illegal = 1'b1;
         end
      endcase
   end

   // ---- stage p1: registered decode output with valid/ready handshake ----
   // Flush outranks accept/hold; a drain without a new accept drops OUT_VALID.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         vld_p1 <= 1'b0;
         dec_p1 <= '0;
      end else if (FLUSH) begin
         vld_p1 <= 1'b0;
         dec_p1 <= '0;
      end else if (accept_p0) begin
         vld_p1 <= 1'b1;
         dec_p1 <= dec_p0;
      end else if (OUT_READY) begin
         vld_p1 <= 1'b0;
      end
   end

   assign OUT_VALID = vld_p1;
   assign ALUC      = dec_p1.aluc;
   assign SHIFT     = dec_p1.shift;
   assign ALUIMM    = dec_p1.aluimm;
   assign IMM_EXT   = dec_p1.imm_ext;
   assign RS        = dec_p1.rs;
   assign RT        = dec_p1.rt;
   assign RD_ADDR   = dec_p1.rd_addr;
   assign SA        = dec_p1.sa;
   assign WREG      = dec_p1.wreg;
   assign M2REG     = dec_p1.m2reg;
   assign WMEM      = dec_p1.wmem;
   assign BRANCH    = dec_p1.branch;
   assign JUMP_TYPE = dec_p1.jump_type;
   assign ILLEGAL   = dec_p1.illegal;

`ifdef ALU_DEC_PERF_CNT_EN
   // Counters stick at all-ones rather than wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   logic                 cnt_en_p0;
   logic [CNT_WIDTH-1:0] dec_cnt_p1;
   logic [CNT_WIDTH-1:0] ill_cnt_p1;

   assign cnt_en_p0 = accept_p0 & ~FLUSH;

   // Count every accepted beat that survives flush, and the illegal subset.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         dec_cnt_p1 <= '0;
         ill_cnt_p1 <= '0;
      end else if (cnt_en_p0) begin
         dec_cnt_p1 <= sat_inc(dec_cnt_p1);
         if (dec_p0.illegal) begin
            ill_cnt_p1 <= sat_inc(ill_cnt_p1);
         end
      end
   end

   assign DEC_COUNT = dec_cnt_p1;
   assign ILL_COUNT = ill_cnt_p1;
`endif

endmodule
